fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the MINI-RISC pipeline. It owns the 11-bit program counter, issues word requests to instruction memory over a req/ack handshake, and presents one instruction plus its PC per cycle to the F/D pipeline register. It absorbs the response when the pipeline stalls, follows branch redirects from Execute, and discards stale memory responses. When no instruction is ready it emits a NOP bubble.

## Interface
- PC_WIDTH, 11, program counter and instruction-memory address width
- INSTR_WIDTH, 16, instruction word width
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- stall_F  in  1  hazard unit: F/D register holds this cycle
- redirect_valid  in  1  branch/jump taken, resolved in Execute
- redirect_pc  in  PC_WIDTH  redirect target
- imem_req  out  1  instruction-memory request
- imem_addr  out  PC_WIDTH  request address; equals the PC while imem_req=1
- imem_ack  in  1  response strobe; imem_rdata valid this cycle
- imem_rdata  in  INSTR_WIDTH  instruction word
- instr_out  out  INSTR_WIDTH  to F/D instruction_in; 0 (NOP) when fetch_valid=0
- pc_out  out  PC_WIDTH  to F/D pc_in; PC of instr_out
- fetch_valid  out  1  instr_out is a real instruction

## Operation
- Registered state: pc, state, hold_buf (INSTR_WIDTH).
- States:
  - IDLE: entered on reset.
  - FETCH: request outstanding.
  - HOLD: response buffered while stalled.
  - DRAIN: discard one stale response.
- imem_req = 1 in FETCH or DRAIN, else 0.
- imem_addr = pc in FETCH; in DRAIN it holds the address of the abandoned request, kept in an internal register until ack.
- IDLE -> FETCH unconditionally after one cycle.
- FETCH, imem_ack=1, redirect_valid=0:
  - If stall_F=0: instr_out=imem_rdata, fetch_valid=1, pc <= pc+1, stay in FETCH.
  - If stall_F=1: hold_buf <= imem_rdata, -> HOLD.
- FETCH, imem_ack=0: instr_out=0, fetch_valid=0, pc_out=pc.
- HOLD: instr_out=hold_buf, fetch_valid=1, imem_req=0.
  - If stall_F=0: pc <= pc+1, -> FETCH.
- Redirect (redirect_valid=1) has priority over stall_F and imem_ack in every state:
  - pc <= redirect_pc. fetch_valid=0 and instr_out=0 that cycle.
  - FETCH with imem_ack=0: the request stays outstanding, -> DRAIN.
  - FETCH with imem_ack=1: the response is discarded, -> FETCH.
  - HOLD: hold_buf is discarded, -> FETCH.
  - DRAIN: remains DRAIN (still owed an ack); pc is updated.
  - IDLE: pc is updated, -> FETCH.
- DRAIN: fetch_valid=0. On imem_ack, data is dropped, -> FETCH.
- PC arithmetic is modulo 2^PC_WIDTH: 0x7FF + 1 = 0x000. A redirect to any value is legal.

## Timing
- Reset values (async, during reset and until the first clock edge after release):
  - state=IDLE, pc=RESET_PC, hold_buf=0.
  - imem_req=0, imem_addr=RESET_PC.
  - instr_out=0, pc_out=RESET_PC, fetch_valid=0.
- First request: imem_req=1 in the 2nd cycle after reset deasserts.
- Outputs are combinational from state and imem inputs. The F/D register captures them on the same edge that advances pc.
- Zero-wait memory (ack in the request cycle) gives one instruction per cycle. An ack N cycles late inserts N NOP bubbles.
- Handshake rules:
  - imem_addr is stable while imem_req=1 and no ack has been received.
  - imem_req never deasserts before ack.
  - Exactly one ack is expected per request.
- Redirect to first new request:
  - 0 cycles when there is no outstanding request (FETCH at ack, HOLD, IDLE).
  - When a request is outstanding, the request at the target starts the cycle after the stale ack.
- Reset mid-request: the outstanding request is abandoned. The memory must accept req dropping with reset.

## Test plan
- Reset release, zero-wait memory returning rdata=addr+0x100 -> fetch_valid is high from cycle 2; pc_out sequence 0,1,2,3 with instr_out 0x100,0x101,0x102,0x103.
- Memory ack delayed 2 cycles -> two fetch_valid=0 cycles with instr_out=0 per instruction; imem_addr constant throughout each wait.
- stall_F held 3 cycles, asserted in the ack cycle of PC=5 -> HOLD; instr_out=rdata(5) for all 3 cycles, imem_req=0; after release pc_out=6 follows with no duplicate or loss.
- redirect_valid with redirect_pc=0x040 while the PC=9 request is waiting for ack (ack arrives 2 cycles later) -> DRAIN, stale data is never marked valid, the next request address is 0x040.
- Redirect in the same cycle as ack plus stall_F -> data discarded, not HOLD; the next fetch is at redirect_pc.
- Redirect to 0x7FE with zero-wait memory -> pc_out 0x7FE, 0x7FF, 0x000 (wrap).

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word requests to instruction memory, feeds F/D.
// Latency: outputs are combinational from state and the memory response; zero-wait memory gives one instruction per cycle.
// Backpressure: stall_F parks an acked word in hold_buf; a redirect while a request is outstanding drains one stale ack.
module fetch_unit #(
   parameter int                    PC_WIDTH    = 11,
   parameter int                    INSTR_WIDTH = 16,
   parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     stall_F,
   input  logic                     redirect_valid,
   input  logic [PC_WIDTH-1:0]      redirect_pc,
   output logic                     imem_req,
   output logic [PC_WIDTH-1:0]      imem_addr,
   input  logic                     imem_ack,
   input  logic [INSTR_WIDTH-1:0]   imem_rdata,
   output logic [INSTR_WIDTH-1:0]   instr_out,
   output logic [PC_WIDTH-1:0]      pc_out,
   output logic                     fetch_valid
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_HOLD,
      S_DRAIN
   } state_t;

   state_t                 state_q, state_d;
   logic [PC_WIDTH-1:0]    pc_q, pc_d;
   logic [INSTR_WIDTH-1:0] hold_buf_q, hold_buf_d;
   logic [PC_WIDTH-1:0]    drain_addr_q, drain_addr_d;
   logic [PC_WIDTH-1:0]    pc_inc;

   assign pc_inc = pc_q + PC_WIDTH'(1);

   // Next-state and output decode; a redirect overrides stall and ack in every state.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      hold_buf_d   = hold_buf_q;
      drain_addr_d = drain_addr_q;
      imem_req     = 1'b0;
      imem_addr    = pc_q;
      instr_out    = '0;
      pc_out       = pc_q;
      fetch_valid  = 1'b0;

      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
            if (redirect_valid) begin
               pc_d = redirect_pc;
            end
         end

         S_FETCH: begin
            imem_req  = 1'b1;
            imem_addr = pc_q;
            if (redirect_valid) begin
               pc_d = redirect_pc;
               if (!imem_ack) begin
                  // Request still in flight: remember its address so it stays stable until the stale ack.
                  drain_addr_d = pc_q;
                  state_d      = S_DRAIN;
               end
            end else if (imem_ack) begin
               instr_out   = imem_rdata;
               fetch_valid = 1'b1;
               if (stall_F) begin
                  hold_buf_d = imem_rdata;
                  state_d    = S_HOLD;
               end else begin
                  pc_d = pc_inc;
               end
            end
         end

         S_HOLD: begin
            if (redirect_valid) begin
               pc_d    = redirect_pc;
               state_d = S_FETCH;
            end else begin
               instr_out   = hold_buf_q;
               fetch_valid = 1'b1;
               if (!stall_F) begin
                  pc_d    = pc_inc;
                  state_d = S_FETCH;
               end
            end
         end

         S_DRAIN: begin
            imem_req  = 1'b1;
            imem_addr = drain_addr_q;
            if (redirect_valid) begin
               pc_d = redirect_pc;
            end
            if (imem_ack) begin
               state_d = S_FETCH;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC;
         hold_buf_q   <= '0;
         drain_addr_q <= RESET_PC;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         hold_buf_q   <= hold_buf_d;
         drain_addr_q <= drain_addr_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: bench-owned memory (rdata = addr + 0x100, programmable ack latency),
// a program-order model checked every cycle, and literal checks on the accepted-instruction log.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall_F;
   logic        redirect_valid;
   logic [10:0] redirect_pc;
   logic        imem_req;
   logic [10:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic [15:0] instr_out;
   logic [10:0] pc_out;
   logic        fetch_valid;

   int n_cmp = 0;
   int n_err = 0;

   // memory model state
   int lat = 0;
   int cnt = 0;

   // program-order model state
   bit          idle;
   bit          held;
   bit          stale;
   logic [10:0] stale_addr;
   logic [10:0] mpc;
   bit          ev;
   bit          er;
   logic [10:0] lpc[$];
   logic [15:0] linstr[$];

   fetch_unit dut (
      .clk            (clk),
      .reset          (reset),
      .stall_F        (stall_F),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .instr_out      (instr_out),
      .pc_out         (pc_out),
      .fetch_valid    (fetch_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mem(input logic [10:0] a);
      return 16'(a) + 16'h0100;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One cycle: advance past the edge, then the memory answers the current request.
   task automatic tick();
      @(posedge clk);
      #1;
      if (reset || !imem_req) begin
         imem_ack   = 1'b0;
         imem_rdata = 16'hBEEF;
         if (reset) cnt = 0;
      end else if (cnt >= lat) begin
         imem_ack   = 1'b1;
         imem_rdata = mem(imem_addr);
         cnt        = 0;
      end else begin
         imem_ack   = 1'b0;
         imem_rdata = 16'hBEEF;
         cnt++;
      end
      #1;
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      stall_F        = 1'b0;
      redirect_valid = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Advance until the DUT requests address a (optionally in a cycle without ack).
   task automatic wait_addr(input logic [10:0] a, input bit need_noack);
      bit found = 1'b0;
      for (int k = 0; k < 300 && !found; k++) begin
         tick();
         if (imem_req && imem_addr == a && (!need_noack || !imem_ack)) found = 1'b1;
      end
      chk("wait_addr_timeout", found, 1);
   endtask

   // Per-cycle comparison against the program-order model.
   always @(negedge clk) begin
      if (reset) begin
         chk("rst_req", imem_req, 0);
         chk("rst_addr", imem_addr, 0);
         chk("rst_valid", fetch_valid, 0);
         chk("rst_instr", instr_out, 0);
         chk("rst_pc_out", pc_out, 0);
         idle  = 1'b1;
         held  = 1'b0;
         stale = 1'b0;
         mpc   = 11'h000;
         lpc.delete();
         linstr.delete();
      end else begin
         er = !idle && !held;
         ev = !redirect_valid && (held || (er && imem_ack && !stale));
         chk("req", imem_req, er);
         chk("valid", fetch_valid, ev);
         chk("instr", instr_out, ev ? mem(mpc) : 16'h0000);
         if (ev) chk("pc_out", pc_out, mpc);
         if (er) chk("addr", imem_addr, stale ? stale_addr : mpc);
         if (redirect_valid) begin
            if (er && !imem_ack && !stale) begin
               stale      = 1'b1;
               stale_addr = mpc;
            end else if (stale && imem_ack) begin
               stale = 1'b0;
            end
            mpc  = redirect_pc;
            held = 1'b0;
         end else if (ev) begin
            if (stall_F) begin
               held = 1'b1;
            end else begin
               held = 1'b0;
               lpc.push_back(pc_out);
               linstr.push_back(instr_out);
               mpc = mpc + 11'd1;
            end
         end else if (stale && imem_ack) begin
            stale = 1'b0;
         end
         idle = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
      $fatal(1, "watchdog");
   end

   initial begin
      reset          = 1'b1;
      stall_F        = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 11'h000;
      imem_ack       = 1'b0;
      imem_rdata     = 16'h0000;

      // Zero-wait stream with a 3-cycle stall on the PC=5 ack.
      lat = 0;
      do_reset();
      chk("first_cycle_req", imem_req, 0);
      tick();
      chk("second_cycle_req", imem_req, 1);
      chk("second_cycle_valid", fetch_valid, 1);
      wait_addr(11'd5, 1'b0);
      stall_F = 1'b1;
      tick();
      chk("hold_req", imem_req, 0);
      chk("hold_instr", instr_out, 16'h0105);
      tick();
      tick();
      stall_F = 1'b0;
      repeat (3) tick();
      chk("a_log_size", lpc.size(), 8);
      for (int i = 0; i < 4; i++) begin
         chk("a_log_pc", lpc[i], i);
         chk("a_log_instr", linstr[i], 16'h0100 + 16'(i));
      end
      chk("a_log_pc5", lpc[5], 5);
      chk("a_log_instr5", linstr[5], 16'h0105);
      chk("a_log_pc6", lpc[6], 6);

      // Two-cycle ack latency: one instruction per three cycles.
      lat = 2;
      do_reset();
      repeat (10) tick();
      chk("b_log_size", lpc.size(), 3);
      chk("b_log_pc2", lpc[2], 2);
      chk("b_log_instr2", linstr[2], 16'h0102);

      // Redirect while the PC=9 request is still waiting.
      lat = 2;
      do_reset();
      wait_addr(11'd9, 1'b1);
      redirect_valid = 1'b1;
      redirect_pc    = 11'h040;
      tick();
      redirect_valid = 1'b0;
      chk("c_drain_req", imem_req, 1);
      chk("c_drain_addr", imem_addr, 11'd9);
      repeat (8) tick();
      chk("c_log_size", lpc.size(), 11);
      chk("c_log_pc8", lpc[8], 8);
      chk("c_log_pc9", lpc[9], 11'h040);
      chk("c_log_instr9", linstr[9], 16'h0140);

      // Redirect in the same cycle as ack and stall: no HOLD.
      lat = 0;
      do_reset();
      wait_addr(11'd3, 1'b0);
      stall_F        = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 11'h100;
      tick();
      stall_F        = 1'b0;
      redirect_valid = 1'b0;
      chk("d_req", imem_req, 1);
      chk("d_addr", imem_addr, 11'h100);
      repeat (3) tick();
      chk("d_log_pc3", lpc[3], 11'h100);
      chk("d_log_instr3", linstr[3], 16'h0200);

      // Redirect near the top of the address space: PC wraps.
      lat = 0;
      do_reset();
      wait_addr(11'd2, 1'b0);
      redirect_valid = 1'b1;
      redirect_pc    = 11'h7FE;
      tick();
      redirect_valid = 1'b0;
      repeat (4) tick();
      chk("e_log_pc2", lpc[2], 11'h7FE);
      chk("e_log_pc3", lpc[3], 11'h7FF);
      chk("e_log_pc4", lpc[4], 11'h000);
      chk("e_log_instr4", linstr[4], 16'h0100);

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
